// File: rtl/id_fwd_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_fwd_stage_if
// Description : Handshake and forwarding bus for the operand-resolution stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_fwd_stage_if #(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 4,
    parameter int FWD_DEPTH = 3
);
    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [RADDR_W-1:0]            in_r1_addr;
    logic [RADDR_W-1:0]            in_r2_addr;
    logic [DATA_W-1:0]             in_r1_rf;
    logic [DATA_W-1:0]             in_r2_rf;
    logic [FWD_DEPTH-1:0]          fwd_we;
    logic [FWD_DEPTH-1:0]          fwd_ld;
    logic [FWD_DEPTH*RADDR_W-1:0]  fwd_reg;
    logic [FWD_DEPTH*DATA_W-1:0]   fwd_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_W-1:0]             out_op1;
    logic [DATA_W-1:0]             out_op2;
    logic                          out_stall;
    logic [15:0]                   stall_cnt;

    modport master (
        output flush, in_valid, in_r1_addr, in_r2_addr, in_r1_rf, in_r2_rf,
        output fwd_we, fwd_ld, fwd_reg, fwd_data, out_ready,
        input  in_ready, out_valid, out_op1, out_op2, out_stall, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_r1_addr, in_r2_addr, in_r1_rf, in_r2_rf,
        input  fwd_we, fwd_ld, fwd_reg, fwd_data, out_ready,
        output in_ready, out_valid, out_op1, out_op2, out_stall, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/id_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_fwd_stage
// Description : Operand forwarding with load-use stall and registered output
//               slot. Define ID_FWD_STALL_CNT_EN to build the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_fwd_stage #(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 4,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    id_fwd_stage_if.slave    bus
);

    localparam logic [RADDR_W-1:0] c_INVALID = {RADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_op1;
    logic [DATA_W-1:0]  r_out_op2;

    logic [DATA_W:0]    w_res1;
    logic [DATA_W:0]    w_res2;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_capture;

    // Returns {hazard, data}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [DATA_W:0] resolve(
        input logic [RADDR_W-1:0]           addr,
        input logic [DATA_W-1:0]            rf,
        input logic [FWD_DEPTH-1:0]         we,
        input logic [FWD_DEPTH-1:0]         ld,
        input logic [FWD_DEPTH*RADDR_W-1:0] regs,
        input logic [FWD_DEPTH*DATA_W-1:0]  data
    );
        logic [DATA_W:0] res;
        res = {1'b0, rf};
        if (addr != c_INVALID) begin
            for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
                if (we[k] && (regs[k*RADDR_W +: RADDR_W] == addr)) begin
                    res = {(ld[k] && (k < LOAD_LAT)), data[k*DATA_W +: DATA_W]};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_res1     = resolve(bus.in_r1_addr, bus.in_r1_rf, bus.fwd_we, bus.fwd_ld,
                             bus.fwd_reg, bus.fwd_data);
        w_res2     = resolve(bus.in_r2_addr, bus.in_r2_rf, bus.fwd_we, bus.fwd_ld,
                             bus.fwd_reg, bus.fwd_data);
        w_hazard   = bus.in_valid && (w_res1[DATA_W] || w_res2[DATA_W]);
        w_in_ready = !rst && !w_hazard && (!r_out_valid || bus.out_ready) && !bus.flush;
        w_capture  = bus.in_valid && w_in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:   if (w_hazard) r_state <= ST_STALL;
                ST_STALL: if (!w_hazard) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
            // A capture never occurs while stalled since hazard forces in_ready low.
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_op1   <= w_res1[DATA_W-1:0];
                r_out_op2   <= w_res2[DATA_W-1:0];
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ID_FWD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 16'h0000;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_stall = w_hazard;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op1   = r_out_op1;
    assign bus.out_op2   = r_out_op2;

endmodule
`default_nettype wire

// File: tb/tb_id_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_fwd_stage
// Description : Directed and random checks of id_fwd_stage against a
//               behavioural model of the forwarding and output-slot rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_fwd_stage;

    localparam int c_DW  = 16;
    localparam int c_AW  = 4;
    localparam int c_FD  = 3;
    localparam int c_LL  = 1;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    id_fwd_stage_if #(.DATA_W(c_DW), .RADDR_W(c_AW), .FWD_DEPTH(c_FD)) bus ();

    id_fwd_stage #(
        .DATA_W(c_DW), .RADDR_W(c_AW), .FWD_DEPTH(c_FD), .LOAD_LAT(c_LL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus held by the bench
    logic            s_valid, s_flush, s_ordy, s_rst;
    logic [c_AW-1:0] s_a1, s_a2;
    logic [c_DW-1:0] s_rf1, s_rf2;
    logic            fw_we   [c_FD];
    logic            fw_ld   [c_FD];
    logic [c_AW-1:0] fw_reg  [c_FD];
    logic [c_DW-1:0] fw_data [c_FD];

    // Reference model of the output slot
    logic            m_valid;
    logic [c_DW-1:0] m_op1, m_op2;
    logic [15:0]     m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Youngest writer of the register wins; loads too young to have data stall.
    function automatic logic [c_DW:0] ref_resolve(input logic [c_AW-1:0] addr,
                                                  input logic [c_DW-1:0] rf);
        if (addr == 4'hF) return {1'b0, rf};
        for (int k = 0; k < c_FD; k++) begin
            if (fw_we[k] && fw_reg[k] == addr)
                return {(fw_ld[k] && k < c_LL), fw_data[k]};
        end
        return {1'b0, rf};
    endfunction

    task automatic clear_fwd();
        for (int k = 0; k < c_FD; k++) begin
            fw_we[k] = 1'b0; fw_ld[k] = 1'b0; fw_reg[k] = '0; fw_data[k] = '0;
        end
    endtask

    task automatic drive();
        rst            = s_rst;
        bus.flush      = s_flush;
        bus.in_valid   = s_valid;
        bus.in_r1_addr = s_a1;
        bus.in_r2_addr = s_a2;
        bus.in_r1_rf   = s_rf1;
        bus.in_r2_rf   = s_rf2;
        bus.out_ready  = s_ordy;
        for (int k = 0; k < c_FD; k++) begin
            bus.fwd_we[k]                = fw_we[k];
            bus.fwd_ld[k]                = fw_ld[k];
            bus.fwd_reg[k*c_AW +: c_AW]  = fw_reg[k];
            bus.fwd_data[k*c_DW +: c_DW] = fw_data[k];
        end
    endtask

    // One clock: check combinational outputs, advance the model, check registers.
    task automatic step();
        logic [c_DW:0] r1, r2;
        logic          haz, rdy, cap;
        drive();
        #1;
        r1  = ref_resolve(s_a1, s_rf1);
        r2  = ref_resolve(s_a2, s_rf2);
        haz = s_valid && (r1[c_DW] || r2[c_DW]);
        rdy = !s_rst && !haz && (!m_valid || s_ordy) && !s_flush;
        cap = s_valid && rdy;
        chk("out_stall", {31'd0, bus.out_stall}, {31'd0, haz});
        chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, rdy});
        if (s_rst) begin
            m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_cnt = '0;
        end else begin
`ifdef ID_FWD_STALL_CNT_EN
            if (haz && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            if (s_flush) m_valid = 1'b0;
            else if (cap) begin
                m_valid = 1'b1; m_op1 = r1[c_DW-1:0]; m_op2 = r2[c_DW-1:0];
            end else if (m_valid && s_ordy) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, m_cnt});
        if (m_valid || s_rst) begin
            chk("out_op1", {16'd0, bus.out_op1}, {16'd0, m_op1});
            chk("out_op2", {16'd0, bus.out_op2}, {16'd0, m_op2});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [c_DW-1:0] held1, held2;
        n_pass = 0; n_total = 0;
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_cnt = '0;
        s_rst = 1'b1; s_flush = 1'b0; s_valid = 1'b0; s_ordy = 1'b1;
        s_a1 = '0; s_a2 = '0; s_rf1 = '0; s_rf2 = '0;
        clear_fwd();
        drive();
        @(negedge clk);

        // Reset
        step(); step();
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_op1",   {16'd0, bus.out_op1},   32'd0);
        chk("rst_cnt",   {16'd0, bus.stall_cnt}, 32'd0);
        s_rst = 1'b0;

        // Plain forward from slot 0
        s_valid = 1'b1; s_a1 = 4'd3; s_rf1 = 16'h0000; s_a2 = 4'd7; s_rf2 = 16'h7777;
        fw_we[0] = 1'b1; fw_reg[0] = 4'd3; fw_data[0] = 16'h1234;
        step();
        chk("fwd_op1", {16'd0, bus.out_op1}, 32'h1234);
        chk("fwd_vld", {31'd0, bus.out_valid}, 32'd1);

        // Youngest match wins, older slot used once the younger drops out
        clear_fwd();
        s_a1 = 4'd5;
        fw_we[0] = 1'b1; fw_reg[0] = 4'd5; fw_data[0] = 16'hAAAA;
        fw_we[2] = 1'b1; fw_reg[2] = 4'd5; fw_data[2] = 16'h5555;
        step();
        chk("prio_young", {16'd0, bus.out_op1}, 32'hAAAA);
        fw_we[0] = 1'b0;
        step();
        chk("prio_old", {16'd0, bus.out_op1}, 32'h5555);

        // Load-use: stall one cycle, then capture once the load reaches slot 1
        clear_fwd();
        s_a1 = 4'd0; s_a2 = 4'd2;
        fw_we[0] = 1'b1; fw_ld[0] = 1'b1; fw_reg[0] = 4'd2;
        step();
        clear_fwd();
        fw_we[1] = 1'b1; fw_ld[1] = 1'b1; fw_reg[1] = 4'd2; fw_data[1] = 16'h00FF;
        step();
        chk("ld_op2", {16'd0, bus.out_op2}, 32'h00FF);
`ifdef ID_FWD_STALL_CNT_EN
        chk("ld_cnt", {16'd0, bus.stall_cnt}, 32'd1);
`endif

        // Backpressure holds the slot, then the next instruction enters at once
        clear_fwd();
        held1 = bus.out_op1; held2 = bus.out_op2;
        s_ordy = 1'b0; s_a1 = 4'd1; s_rf1 = 16'hC0DE; s_a2 = 4'd4; s_rf2 = 16'hF00D;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_op1", {16'd0, bus.out_op1}, {16'd0, held1});
            chk("bp_op2", {16'd0, bus.out_op2}, {16'd0, held2});
        end
        s_ordy = 1'b1;
        step();
        chk("bp_new", {16'd0, bus.out_op1}, 32'hC0DE);

        // Flush while a hazard is pending
        fw_we[0] = 1'b1; fw_ld[0] = 1'b1; fw_reg[0] = 4'd1;
        step();
        s_flush = 1'b1;
        step();
        chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
        s_flush = 1'b0; clear_fwd();
        step();

        // Invalid address never matches even a load writer
        clear_fwd();
        s_a1 = 4'hF; s_rf1 = 16'hBEEF;
        fw_we[0] = 1'b1; fw_ld[0] = 1'b1; fw_reg[0] = 4'hF; fw_data[0] = 16'h0BAD;
        step();
        chk("inv_op1", {16'd0, bus.out_op1}, 32'hBEEF);

        // Reset during a stall
        s_a1 = 4'd6; fw_reg[0] = 4'd6;
        step();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            s_rst   = ($urandom_range(0, 99) == 0);
            s_flush = ($urandom_range(0, 19) == 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_ordy  = ($urandom_range(0, 3) != 0);
            s_a1    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            s_a2    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
            s_rf1   = 16'($urandom);
            s_rf2   = 16'($urandom);
            for (int k = 0; k < c_FD; k++) begin
                fw_we[k]   = $urandom_range(0, 1) == 1;
                fw_ld[k]   = $urandom_range(0, 2) == 0;
                fw_reg[k]  = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 7));
                fw_data[k] = 16'($urandom);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised operand-resolution stage between register-file read and execute. It forwards from up to FWD_DEPTH in-flight writers, detects load-use hazards and stalls the instruction with a small FSM. Resolved operands are registered into an output slot with a valid/ready handshake, and the stage supports flush. It replaces the fixed three-deep combinational forwarding in the decode path.

## Interface
- DATA_W, 16, operand/result width
- RADDR_W, 4, register address width; all-ones address = invalid, never matches
- FWD_DEPTH, 3, number of forwarding slots; slot 0 = youngest (EX), slot FWD_DEPTH-1 = oldest
- LOAD_LAT, 1, slots 0..LOAD_LAT-1 holding a load cannot forward (data not yet available); must be ≤ FWD_DEPTH
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard output slot and any stalled instruction
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_r1_addr, in_r2_addr  in  RADDR_W  source register addresses
- in_r1_rf, in_r2_rf  in  DATA_W  register-file read data
- fwd_we  in  FWD_DEPTH  slot k will write a register
- fwd_ld  in  FWD_DEPTH  slot k is a memory load
- fwd_reg  in  FWD_DEPTH*RADDR_W  destination of slot k, bits [k*RADDR_W +: RADDR_W]
- fwd_data  in  FWD_DEPTH*DATA_W  result of slot k
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  downstream accepts
- out_op1, out_op2  out  DATA_W  resolved operands
- out_stall  out  1  load-use hazard holding the current input
- stall_cnt  out  16  hazard-cycle counter (see Configuration)

## Operation
- Operand resolution, per source, combinational. The candidate is the lowest-index slot k with fwd_we[k]=1 and fwd_reg[k]==addr. With no candidate, or addr invalid, the register-file data is used.
- If the candidate has fwd_ld[k]=1 and k<LOAD_LAT, a hazard is raised. An older non-matching slot never overrides a younger match.
- hazard = in_valid & (hazard_r1 | hazard_r2).
- in_ready = !hazard & (!out_valid | out_ready) & !flush.
- Capture: when in_valid & in_ready, out_op1/out_op2 load the resolved values and out_valid goes to 1 on the next edge.
- Release: when out_valid & out_ready & no capture, out_valid goes to 0.
- The output slot holds its values stable while out_valid & !out_ready.
- FSM states: RUN, STALL.
  - RUN→STALL when hazard.
  - STALL→RUN when !hazard, or when in_valid drops.
  - Any state→RUN on flush.
  - out_stall = hazard, independent of state.
  - STALL performs no capture; operands are re-evaluated every cycle as the load advances to slot ≥ LOAD_LAT.
- Flush has priority over capture and release: the next edge gives out_valid=0 and state RUN. The inputs in that cycle are dropped.
- Simultaneous capture and release: the new data replaces the old and out_valid stays 1.

## Timing
- Latency 1 cycle, input accept to out_valid.
- Throughput is 1 per cycle with out_ready held high.
- Stall length = LOAD_LAT − k cycles for a matching load at slot k, provided upstream slots advance.
- Reset values: out_valid=0, out_op1=0, out_op2=0, state RUN, stall_cnt=0.
- During reset, in_ready=0 and out_stall reflects the combinational hazard only.
- Reset mid-stall returns to RUN and drops the stalled instruction.

## Configuration
- ID_FWD_STALL_CNT_EN defined: stall_cnt increments by 1 on each clk edge where out_stall=1 and rst=0. It saturates at 16'hFFFF and is cleared only by rst.
- Not defined: stall_cnt is tied to 0 and no counter register is built.

## Test plan
- Plain forward: r1=3 with slot0 writing r3=16'h1234 and RF r3=16'h0000 → out_op1=16'h1234 one cycle later, out_valid=1.
- Priority: slot0 and slot2 both write r5 (16'hAAAA, 16'h5555) → out_op1=16'hAAAA. With slot0 fwd_we=0 → 16'h5555.
- Load-use: LOAD_LAT=1, slot0 load to r2, in_r2_addr=2.
  - Cycle 0: out_stall=1, in_ready=0.
  - Cycle 1: load moves to slot1 with data 16'h00FF → capture, out_op2=16'h00FF.
  - With the macro defined, stall_cnt=1.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → out_op1/op2 unchanged and in_ready=0. Then out_ready=1 → next instruction captured the same cycle.
- Flush during stall: hazard active plus flush → next cycle out_valid=0, state RUN, in_ready follows normal rules.
- Invalid address: in_r1_addr=4'hF with slot0 writing 4'hF → RF data used, no hazard.
